// File: rtl/hcb_pkg.sv
// Shared types and helpers for the sequential clause-evaluation engine.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package hcb_pkg;

  // Sample framing FSM: IDLE waits for packet 0, ACC accumulates packets,
  // DRAIN discards a mis-framed sample up to its s_last, OUT holds the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } hcb_state_t;

  // Index width for a dimension of n entries; never zero so a single-entry
  // dimension still gets a usable 1-bit port.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int class_idx_w(input int class_num);
    return idx_w(class_num);
  endfunction

  function automatic int clause_idx_w(input int clause_num);
    return idx_w(clause_num);
  endfunction

  function automatic int packet_idx_w(input int packets_num);
    return idx_w(packets_num);
  endfunction

endpackage

// Literal vector for a packet of w features: {~x, x}, so 2*w bits.
`ifndef HCB_LIT_VEC
`define HCB_LIT_VEC(w) logic [2*(w)-1:0]
`endif

// File: rtl/hcb_packet_eval.sv
// Evaluates one feature packet against one packet's include masks for every clause.
// Latency: purely combinational.
// Backpressure: none; the caller chooses which packet's masks are presented.
// Ports: x (W features), mask [class][clause] (2W include bits, [W-1:0] for x,
//        [2W-1:W] for ~x); lit_ok / pkt_any [class] (one bit per clause).
module hcb_packet_eval
  import hcb_pkg::*;
#(
  parameter int CLASS_NUM  = 10,
  parameter int CLAUSE_NUM = 100,
  parameter int W          = 64
) (
  input  logic [W-1:0]          x,
  input  logic [2*W-1:0]        mask    [CLASS_NUM][CLAUSE_NUM],
  output logic [CLAUSE_NUM-1:0] lit_ok  [CLASS_NUM],
  output logic [CLAUSE_NUM-1:0] pkt_any [CLASS_NUM]
);

  `HCB_LIT_VEC(W) lit;

  assign lit = {~x, x};

  // A literal only matters where its include bit is set; excluded literals
  // are forced to 1 so they cannot break the AND.
  always_comb begin
    for (int c = 0; c < CLASS_NUM; c++) begin
      lit_ok[c]  = '0;
      pkt_any[c] = '0;
      for (int k = 0; k < CLAUSE_NUM; k++) begin
        lit_ok[c][k]  = &(lit | ~mask[c][k]);
        pkt_any[c][k] = |mask[c][k];
      end
    end
  end

endmodule

// File: rtl/hcb_seq_evaluator.sv
// Sequential Tsetlin clause evaluator: folds PACKETS_NUM feature packets into per-class clause vectors.
// Latency: result valid the cycle after the last packet is accepted; one sample per PACKETS_NUM+1 cycles.
// Backpressure: s_ready drops while a result waits for m_ready; include-mask writes only land in IDLE.
// Ports: clk/rst (sync, active-high); s_x/s_valid/s_last/s_ready packet stream;
//        cfg_we/cfg_class/cfg_clause/cfg_packet/cfg_mask mask writes, cfg_err reject pulse;
//        m_clause/m_valid/m_ready result; frame_err pulse when a sample is discarded.
module hcb_seq_evaluator
  import hcb_pkg::*;
#(
  parameter int CLASS_NUM              = 10,
  parameter int CLAUSE_NUM             = 100,
  parameter int PACKETS_NUM            = 13,
  parameter int C_S00_AXIS_TDATA_WIDTH = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]       s_x,
  input  logic                                    s_valid,
  input  logic                                    s_last,
  output logic                                    s_ready,
  input  logic                                    cfg_we,
  input  logic [class_idx_w(CLASS_NUM)-1:0]       cfg_class,
  input  logic [clause_idx_w(CLAUSE_NUM)-1:0]     cfg_clause,
  input  logic [packet_idx_w(PACKETS_NUM)-1:0]    cfg_packet,
  input  logic [2*C_S00_AXIS_TDATA_WIDTH-1:0]     cfg_mask,
  output logic                                    cfg_err,
  output logic [CLAUSE_NUM-1:0]                   m_clause [CLASS_NUM],
  output logic                                    m_valid,
  input  logic                                    m_ready,
  output logic                                    frame_err
);

  localparam int W  = C_S00_AXIS_TDATA_WIDTH;
  localparam int LW = 2 * W;
  localparam int PW = packet_idx_w(PACKETS_NUM);
  localparam logic [PW-1:0] LAST_PKT = PW'(PACKETS_NUM - 1);

  hcb_state_t state_q, state_d;

  logic [LW-1:0]         inc      [CLASS_NUM][CLAUSE_NUM][PACKETS_NUM];
  logic [LW-1:0]         mask_sel [CLASS_NUM][CLAUSE_NUM];
  logic [CLAUSE_NUM-1:0] lit_ok   [CLASS_NUM];
  logic [CLAUSE_NUM-1:0] pkt_any  [CLASS_NUM];
  logic [CLAUSE_NUM-1:0] acc_q    [CLASS_NUM];
  logic [CLAUSE_NUM-1:0] any_q    [CLASS_NUM];
  logic [CLAUSE_NUM-1:0] acc_nx   [CLASS_NUM];
  logic [CLAUSE_NUM-1:0] any_nx   [CLASS_NUM];
  logic [PW-1:0]         pkt_cnt_q;

  logic beat, last_idx, acc_upd, latch, frame_err_d;
  logic cfg_in_range, cfg_ok;
  logic cfg_err_q, frame_err_q;

  assign s_ready   = !rst && (state_q != OUT);
  assign m_valid   = !rst && (state_q == OUT);
  assign beat      = s_valid && s_ready;
  assign last_idx  = (pkt_cnt_q == LAST_PKT);
  assign cfg_err   = cfg_err_q;
  assign frame_err = frame_err_q;

  // The single evaluator sees the masks of the packet currently expected;
  // pkt_cnt is 0 in IDLE so packet 0 is served there too.
  always_comb begin
    for (int c = 0; c < CLASS_NUM; c++)
      for (int k = 0; k < CLAUSE_NUM; k++)
        mask_sel[c][k] = inc[c][k][pkt_cnt_q];
  end

  hcb_packet_eval #(
    .CLASS_NUM  (CLASS_NUM),
    .CLAUSE_NUM (CLAUSE_NUM),
    .W          (W)
  ) u_packet_eval (
    .x       (s_x),
    .mask    (mask_sel),
    .lit_ok  (lit_ok),
    .pkt_any (pkt_any)
  );

  always_comb begin
    for (int c = 0; c < CLASS_NUM; c++) begin
      acc_nx[c] = acc_q[c] & lit_ok[c];
      any_nx[c] = any_q[c] | pkt_any[c];
    end
  end

  // Next-state logic. IDLE and ACC share the beat handling: in IDLE the
  // accumulator already holds its all-1 / none-included start values.
  always_comb begin
    state_d     = state_q;
    acc_upd     = 1'b0;
    latch       = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        if (beat) begin
          if (s_last && last_idx) begin
            latch   = 1'b1;
            state_d = OUT;
          end else if (s_last) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end else if (last_idx) begin
            frame_err_d = 1'b1;
            state_d     = DRAIN;
          end else begin
            acc_upd = 1'b1;
            state_d = ACC;
          end
        end
      end
      DRAIN: if (beat && s_last) state_d = IDLE;
      OUT:   if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      for (int c = 0; c < CLASS_NUM; c++) begin
        acc_q[c]    <= '1;
        any_q[c]    <= '0;
        m_clause[c] <= '0;
      end
    end else begin
      frame_err_q <= frame_err_d;
      if (acc_upd) begin
        pkt_cnt_q <= pkt_cnt_q + PW'(1);
        for (int c = 0; c < CLASS_NUM; c++) begin
          acc_q[c] <= acc_nx[c];
          any_q[c] <= any_nx[c];
        end
      end else if (state_d == IDLE) begin
        // Every path back to IDLE restarts the accumulation.
        pkt_cnt_q <= '0;
        for (int c = 0; c < CLASS_NUM; c++) begin
          acc_q[c] <= '1;
          any_q[c] <= '0;
        end
      end
      if (latch) begin
        // Clauses without any include bit are forced to 0.
        for (int c = 0; c < CLASS_NUM; c++)
          m_clause[c] <= acc_nx[c] & any_nx[c];
      end
    end
  end

  // Mask writes must not race a packet that is reading the store.
  assign cfg_in_range = (int'(cfg_class)  < CLASS_NUM)  &&
                        (int'(cfg_clause) < CLAUSE_NUM) &&
                        (int'(cfg_packet) < PACKETS_NUM);
  assign cfg_ok = cfg_we && (state_q == IDLE) && !beat && cfg_in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
      for (int c = 0; c < CLASS_NUM; c++)
        for (int k = 0; k < CLAUSE_NUM; k++)
          for (int p = 0; p < PACKETS_NUM; p++)
            inc[c][k][p] <= '0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      if (cfg_ok) inc[cfg_class][cfg_clause][cfg_packet] <= cfg_mask;
    end
  end

endmodule

// File: tb/tb_hcb_seq_evaluator.sv
// Directed bench for hcb_seq_evaluator with W=4, 2 packets, 2 classes, 2 clauses.
// Latency: checks result one cycle after the last accepted packet.
// Backpressure: exercises m_ready hold, drain and cfg rejection.
module tb_hcb_seq_evaluator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] s_x;
  logic       s_valid, s_last, s_ready;
  logic       cfg_we;
  logic       cfg_class, cfg_clause, cfg_packet;
  logic [7:0] cfg_mask;
  logic       cfg_err;
  logic [1:0] m_clause [2];
  logic       m_valid, m_ready, frame_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hcb_seq_evaluator #(
    .CLASS_NUM              (2),
    .CLAUSE_NUM             (2),
    .PACKETS_NUM            (2),
    .C_S00_AXIS_TDATA_WIDTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_x        (s_x),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .cfg_we     (cfg_we),
    .cfg_class  (cfg_class),
    .cfg_clause (cfg_clause),
    .cfg_packet (cfg_packet),
    .cfg_mask   (cfg_mask),
    .cfg_err    (cfg_err),
    .m_clause   (m_clause),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_err  (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] clauses();
    return {m_clause[1], m_clause[0]};
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cfg_write(input logic c, input logic k, input logic p, input logic [7:0] m);
    cfg_we = 1'b1; cfg_class = c; cfg_clause = k; cfg_packet = p; cfg_mask = m;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_accept", cfg_err, 1'b0);
  endtask

  task automatic beat(input logic [3:0] x, input logic last);
    s_valid = 1'b1; s_x = x; s_last = last;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic take();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("take_mvalid", m_valid, 1'b0);
    chk("take_sready", s_ready, 1'b1);
  endtask

  task automatic sample(input string tag, input logic [3:0] x0, input logic [3:0] x1,
                        input logic [3:0] exp);
    beat(x0, 1'b0);
    chk({tag, "_mid_mvalid"}, m_valid, 1'b0);
    beat(x1, 1'b1);
    chk({tag, "_mvalid"}, m_valid, 1'b1);
    chk({tag, "_sready"}, s_ready, 1'b0);
    chk({tag, "_clause"}, clauses(), exp);
  endtask

  initial begin
    rst = 1'b1; s_x = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    cfg_we = 1'b0; cfg_class = 1'b0; cfg_clause = 1'b0; cfg_packet = 1'b0; cfg_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_sready", s_ready, 1'b0);
    chk("rst_mvalid", m_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_clause", clauses(), 4'h0);
    chk("rst_cfgerr", cfg_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("idle_sready", s_ready, 1'b1);

    // c00: x[0] of pkt0 and ~x[0] of pkt1; c11: ~x[3] of pkt0.
    cfg_write(1'b0, 1'b0, 1'b0, 8'h01);
    cfg_write(1'b0, 1'b0, 1'b1, 8'h10);
    cfg_write(1'b1, 1'b1, 1'b0, 8'h80);
    sample("basic", 4'h1, 4'h0, 4'b1001);
    take();
    sample("x0fail", 4'h0, 4'h0, 4'b1000);
    take();
    cfg_write(1'b0, 1'b0, 1'b0, 8'h00);
    sample("notx_only", 4'h0, 4'h0, 4'b1001);
    take();
    cfg_write(1'b0, 1'b0, 1'b0, 8'h01);

    // Early s_last: sample discarded, accumulator restarts clean.
    beat(4'h0, 1'b1);
    chk("early_ferr", frame_err, 1'b1);
    chk("early_mvalid", m_valid, 1'b0);
    @(negedge clk);
    chk("early_ferr_pulse", frame_err, 1'b0);
    sample("after_early", 4'h1, 4'h0, 4'b1001);
    take();

    // Missing s_last: third beat drained.
    beat(4'h1, 1'b0);
    beat(4'h0, 1'b0);
    chk("late_ferr", frame_err, 1'b1);
    chk("drain_sready", s_ready, 1'b1);
    beat(4'h0, 1'b1);
    chk("drain_mvalid", m_valid, 1'b0);
    chk("drain_ferr", frame_err, 1'b0);
    chk("drain_sready2", s_ready, 1'b1);
    sample("after_drain", 4'h1, 4'h0, 4'b1001);

    // Hold the result; offered packets and mask writes must be refused.
    s_valid = 1'b1; s_x = 4'h0; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cfg_we = (i == 3); cfg_class = 1'b0; cfg_clause = 1'b0; cfg_packet = 1'b0; cfg_mask = 8'h00;
      @(negedge clk);
      chk("hold_clause", clauses(), 4'b1001);
      chk("hold_mvalid", m_valid, 1'b1);
      chk("hold_sready", s_ready, 1'b0);
      chk("hold_cfgerr", cfg_err, (i == 3) ? 1'b1 : 1'b0);
    end
    cfg_we = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    take();
    sample("mask_kept", 4'h0, 4'h0, 4'b1000);
    take();
    sample("pre_rst", 4'h1, 4'h0, 4'b1001);
    take();

    // Mid-sample: mask write rejected, then reset discards everything.
    beat(4'h1, 1'b0);
    cfg_we = 1'b1; cfg_mask = 8'h00;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("acc_cfgerr", cfg_err, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sready", s_ready, 1'b0);
    chk("midrst_mvalid", m_valid, 1'b0);
    chk("midrst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_clause", clauses(), 4'h0);
    chk("midrst_mvalid2", m_valid, 1'b0);
    sample("cleared", 4'h1, 4'h0, 4'b0000);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
